// File: rtl/fir_xifu_ctrl.sv
// Tracking queue and head FSM for offloaded FIR instructions on the XIF interface.
// Entries issue in order, get committed/killed by ID, optionally go through one memory access, and retire in order.
module fir_xifu_ctrl #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned ID_W  = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       issue_valid_i,
   input  logic [ID_W-1:0]            issue_id_i,
   input  logic                       issue_is_mem_i,
   input  logic                       issue_we_i,
   output logic                       issue_ready_o,
   input  logic                       commit_valid_i,
   input  logic [ID_W-1:0]            commit_id_i,
   input  logic                       commit_kill_i,
   output logic                       mem_valid_o,
   input  logic                       mem_ready_i,
   output logic [ID_W-1:0]            mem_id_o,
   output logic                       mem_we_o,
   input  logic                       mem_result_valid_i,
   input  logic [ID_W-1:0]            mem_result_id_i,
   output logic                       retire_valid_o,
   output logic [ID_W-1:0]            retire_id_o,
   output logic                       retire_killed_o,
   output logic                       busy_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       protocol_err_o,
   output logic [1:0]                 state_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid and its payload hold steady until that edge.
   typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_RESP, RETIRE} state_e;

   state_e            state_q;
   logic [ID_W-1:0]   id_q [DEPTH];
   logic [DEPTH-1:0]  is_mem_q, we_q, committed_q, killed_q;
   logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
   logic [CW-1:0]     count_q;
   logic              err_q;

   logic              issue_fire, pop;
   logic              cm_hit, cm_new;
   logic [PW-1:0]     cm_idx;
   logic              head_valid;

   assign issue_ready_o = (count_q < CW'(DEPTH));
   assign issue_fire    = issue_valid_i && issue_ready_o;
   assign pop           = (state_q == RETIRE);
   assign head_valid    = (count_q != '0);

   // Oldest queued, uncommitted entry with a matching id wins; otherwise the entry being written now.
   always_comb begin
      cm_hit = 1'b0;
      cm_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         automatic logic [PW-1:0] idx = rd_ptr_q + PW'(i);
         if (!cm_hit && commit_valid_i && (CW'(i) < count_q) &&
             !committed_q[idx] && (id_q[idx] == commit_id_i)) begin
            cm_hit = 1'b1;
            cm_idx = idx;
         end
      end
      cm_new = commit_valid_i && !cm_hit && issue_fire && (issue_id_i == commit_id_i);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         committed_q <= '0;
         killed_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         if (issue_fire) begin
            id_q[wr_ptr_q]        <= issue_id_i;
            is_mem_q[wr_ptr_q]    <= issue_is_mem_i;
            we_q[wr_ptr_q]        <= issue_we_i;
            committed_q[wr_ptr_q] <= cm_new;
            killed_q[wr_ptr_q]    <= cm_new && commit_kill_i;
            wr_ptr_q              <= wr_ptr_q + 1'b1;
         end
         if (cm_hit) begin
            committed_q[cm_idx] <= 1'b1;
            killed_q[cm_idx]    <= commit_kill_i;
         end
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (issue_fire && !pop)      count_q <= count_q + 1'b1;
         else if (!issue_fire && pop) count_q <= count_q - 1'b1;

         if (mem_result_valid_i &&
             !((state_q == MEM_RESP) && (mem_result_id_i == id_q[rd_ptr_q])))
            err_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (head_valid) begin
                  if (killed_q[rd_ptr_q] || (committed_q[rd_ptr_q] && !is_mem_q[rd_ptr_q]))
                     state_q <= RETIRE;
                  else if (committed_q[rd_ptr_q])
                     state_q <= MEM_REQ;
               end
            end
            MEM_REQ:  if (mem_ready_i) state_q <= MEM_RESP;
            MEM_RESP: if (mem_result_valid_i && (mem_result_id_i == id_q[rd_ptr_q])) state_q <= RETIRE;
            RETIRE:   state_q <= IDLE;
            default:  state_q <= IDLE;
         endcase
      end
   end

   assign mem_valid_o     = (state_q == MEM_REQ);
   assign mem_id_o        = mem_valid_o ? id_q[rd_ptr_q] : '0;
   assign mem_we_o        = mem_valid_o && we_q[rd_ptr_q];
   assign retire_valid_o  = pop;
   assign retire_id_o     = pop ? id_q[rd_ptr_q] : '0;
   assign retire_killed_o = pop && killed_q[rd_ptr_q];
   assign busy_o          = head_valid || (state_q != IDLE);
   assign count_o         = count_q;
   assign protocol_err_o  = err_q;
   assign state_o         = state_q;

endmodule

// File: tb/tb_fir_xifu_ctrl.sv
// Bench for fir_xifu_ctrl: directed cycle checks plus an in-order retire scoreboard.
module tb_fir_xifu_ctrl;

   localparam int DEPTH = 4;
   localparam int ID_W  = 4;

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic            issue_valid_i, issue_is_mem_i, issue_we_i, issue_ready_o;
   logic [ID_W-1:0] issue_id_i;
   logic            commit_valid_i, commit_kill_i;
   logic [ID_W-1:0] commit_id_i;
   logic            mem_valid_o, mem_ready_i, mem_we_o;
   logic [ID_W-1:0] mem_id_o;
   logic            mem_result_valid_i;
   logic [ID_W-1:0] mem_result_id_i;
   logic            retire_valid_o, retire_killed_o;
   logic [ID_W-1:0] retire_id_o;
   logic            busy_o, protocol_err_o;
   logic [2:0]      count_o;
   logic [1:0]      state_o;

   logic [ID_W:0]   exp_q[$];
   int              n_tests = 0;
   int              n_fail  = 0;

   fir_xifu_ctrl #(.DEPTH(DEPTH), .ID_W(ID_W)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .issue_valid_i(issue_valid_i), .issue_id_i(issue_id_i), .issue_is_mem_i(issue_is_mem_i),
      .issue_we_i(issue_we_i), .issue_ready_o(issue_ready_o),
      .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i), .commit_kill_i(commit_kill_i),
      .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i), .mem_id_o(mem_id_o), .mem_we_o(mem_we_o),
      .mem_result_valid_i(mem_result_valid_i), .mem_result_id_i(mem_result_id_i),
      .retire_valid_o(retire_valid_o), .retire_id_o(retire_id_o), .retire_killed_o(retire_killed_o),
      .busy_o(busy_o), .count_o(count_o), .protocol_err_o(protocol_err_o), .state_o(state_o)
   );

   // clock / reset
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic next();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      issue_valid_i = 1'b0; issue_id_i = '0; issue_is_mem_i = 1'b0; issue_we_i = 1'b0;
      commit_valid_i = 1'b0; commit_id_i = '0; commit_kill_i = 1'b0;
      mem_ready_i = 1'b0; mem_result_valid_i = 1'b0; mem_result_id_i = '0;
   endtask

   task automatic drive_issue(input logic [ID_W-1:0] id, input logic is_mem, input logic we);
      issue_valid_i = 1'b1; issue_id_i = id; issue_is_mem_i = is_mem; issue_we_i = we;
   endtask

   task automatic drive_commit(input logic [ID_W-1:0] id, input logic kill);
      commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      while (busy_o && t < 100) begin
         next();
         t++;
      end
      check(tag, busy_o, 0);
   endtask

   // scoreboard: retires must come out in queued order with the planned killed flag
   always @(negedge clk_i) begin
      if (!rst_i && retire_valid_o) begin
         if (exp_q.size() == 0)
            check("sb_retire_when_empty", exp_q.size(), 1);
         else
            check("sb_retire", {retire_killed_o, retire_id_o}, exp_q.pop_front());
      end
   end

   initial begin
      idle_inputs();
      rst_i = 1'b1;
      next();
      next();
      rst_i = 1'b0;
      check("rst_ready", issue_ready_o, 1);
      check("rst_count", count_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_mem_valid", mem_valid_o, 0);
      check("rst_retire", retire_valid_o, 0);
      check("rst_err", protocol_err_o, 0);
      check("rst_state", state_o, 0);

      // non-mem instruction, issue and commit together
      drive_issue(4'd3, 1'b0, 1'b0);
      drive_commit(4'd3, 1'b0);
      exp_q.push_back({1'b0, 4'd3});
      next(); idle_inputs();
      check("nm_c1_retire", retire_valid_o, 0);
      check("nm_c1_count", count_o, 1);
      next();
      check("nm_c2_retire", retire_valid_o, 1);
      check("nm_c2_id", retire_id_o, 3);
      check("nm_c2_killed", retire_killed_o, 0);
      next();
      check("nm_c3_retire", retire_valid_o, 0);
      check("nm_c3_id_zero", retire_id_o, 0);
      check("nm_c3_count", count_o, 0);

      // memory load
      drive_issue(4'd5, 1'b1, 1'b0);
      drive_commit(4'd5, 1'b0);
      exp_q.push_back({1'b0, 4'd5});
      next(); idle_inputs();
      check("ld_c1_mem_valid", mem_valid_o, 0);
      check("ld_c1_mem_id_zero", mem_id_o, 0);
      next();
      check("ld_c2_mem_valid", mem_valid_o, 1);
      check("ld_c2_mem_id", mem_id_o, 5);
      check("ld_c2_mem_we", mem_we_o, 0);
      mem_ready_i = 1'b1;
      next(); idle_inputs();
      check("ld_c3_mem_valid", mem_valid_o, 0);
      mem_result_valid_i = 1'b1; mem_result_id_i = 4'd5;
      next(); idle_inputs();
      check("ld_c4_retire", retire_valid_o, 1);
      check("ld_c4_id", retire_id_o, 5);
      next();
      check("ld_err", protocol_err_o, 0);

      // store under backpressure
      drive_issue(4'd9, 1'b1, 1'b1);
      drive_commit(4'd9, 1'b0);
      exp_q.push_back({1'b0, 4'd9});
      next(); idle_inputs();
      next();
      check("bp_c2_valid", mem_valid_o, 1);
      for (int i = 0; i < 3; i++) begin
         next();
         check("bp_hold_valid", mem_valid_o, 1);
         check("bp_hold_id", mem_id_o, 9);
         check("bp_hold_we", mem_we_o, 1);
      end
      mem_ready_i = 1'b1;
      next(); idle_inputs();
      check("bp_after_valid", mem_valid_o, 0);
      mem_result_valid_i = 1'b1; mem_result_id_i = 4'd9;
      next(); idle_inputs();
      wait_idle("bp_drain");

      // full queue, kill the head
      for (int i = 0; i < 4; i++) begin
         drive_issue(4'(10 + i), 1'b0, 1'b0);
         exp_q.push_back({(i == 0) ? 1'b1 : 1'b0, 4'(10 + i)});
         next();
      end
      idle_inputs();
      check("full_ready", issue_ready_o, 0);
      check("full_count", count_o, 4);
      drive_commit(4'd10, 1'b1);
      drive_issue(4'd14, 1'b0, 1'b0);
      next(); idle_inputs();
      check("full_c5_retire", retire_valid_o, 0);
      check("full_c5_count", count_o, 4);
      next();
      check("full_c6_retire", retire_valid_o, 1);
      check("full_c6_killed", retire_killed_o, 1);
      check("full_c6_ready", issue_ready_o, 0);
      drive_commit(4'd11, 1'b0);
      next();
      check("full_c7_ready", issue_ready_o, 1);
      check("full_c7_count", count_o, 3);
      drive_commit(4'd12, 1'b0);
      next();
      drive_commit(4'd13, 1'b0);
      next(); idle_inputs();
      wait_idle("full_drain");

      // out-of-order commit, then a stray result
      drive_issue(4'd1, 1'b0, 1'b0);
      exp_q.push_back({1'b0, 4'd1});
      next();
      drive_issue(4'd2, 1'b0, 1'b0);
      exp_q.push_back({1'b0, 4'd2});
      next(); idle_inputs();
      drive_commit(4'd2, 1'b0);
      next(); idle_inputs();
      drive_commit(4'd1, 1'b0);
      next(); idle_inputs();
      wait_idle("ooo_drain");
      check("ooo_err_before", protocol_err_o, 0);
      mem_result_valid_i = 1'b1; mem_result_id_i = 4'd7;
      next(); idle_inputs();
      check("stray_err", protocol_err_o, 1);
      next();
      check("stray_err_sticky", protocol_err_o, 1);

      // reset while the memory request is outstanding
      drive_issue(4'd4, 1'b1, 1'b0);
      drive_commit(4'd4, 1'b0);
      next(); idle_inputs();
      next();
      check("mrst_mem_valid_pre", mem_valid_o, 1);
      rst_i = 1'b1;
      next();
      rst_i = 1'b0;
      check("mrst_mem_valid", mem_valid_o, 0);
      check("mrst_count", count_o, 0);
      check("mrst_busy", busy_o, 0);
      check("mrst_err", protocol_err_o, 0);
      check("mrst_ready", issue_ready_o, 1);
      for (int i = 0; i < 4; i++) begin
         next();
         check("mrst_no_retire", retire_valid_o, 0);
      end

      // random non-mem traffic with random kills
      for (int k = 0; k < 12; k++) begin
         logic [ID_W-1:0] rid;
         logic            rk;
         int              t;
         rid = ID_W'($urandom_range(0, 15));
         rk  = 1'($urandom_range(0, 1));
         t = 0;
         while (!issue_ready_o && t < 20) begin
            next();
            t++;
         end
         check("rnd_ready", issue_ready_o, 1);
         drive_issue(rid, 1'b0, 1'b0);
         drive_commit(rid, rk);
         exp_q.push_back({rk, rid});
         next(); idle_inputs();
      end
      wait_idle("rnd_drain");
      next();
      check("sb_empty", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fir_xifu_ctrl.md
FIR_XIFU_CTRL -- requirements
Module: fir_xifu_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning tracking-queue entries; power of two, 2..16.
REQ-002 SHALL have parameter ID_W, default 4, meaning XIF instruction-id width.
REQ-003 SHALL have clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have issue_valid_i  in  1, issue_id_i  in  ID_W, issue_is_mem_i  in  1, issue_we_i  in  1: an offloaded FIR instruction accepted by ID.
REQ-006 SHALL have issue_ready_o  out  1  queue can accept an instruction.
REQ-007 SHALL have commit_valid_i  in  1, commit_id_i  in  ID_W, commit_kill_i  in  1: core commit/kill.
REQ-008 SHALL have mem_valid_o  out  1, mem_ready_i  in  1, mem_id_o  out  ID_W, mem_we_o  out  1: memory request toward EX.
REQ-009 SHALL have mem_result_valid_i  in  1, mem_result_id_i  in  ID_W: memory result.
REQ-010 SHALL have retire_valid_o  out  1, retire_id_o  out  ID_W, retire_killed_o  out  1: retire pulse to WB.
REQ-011 SHALL have busy_o  out  1  (queue non-empty or FSM not IDLE) and count_o  out  $clog2(DEPTH)+1  occupancy.
REQ-012 SHALL have protocol_err_o  out  1  sticky protocol-violation flag.

Function
REQ-013 SHALL hold an in-order queue; each entry stores id, is_mem, we, committed, killed.
REQ-014 SHALL accept an issue on a cycle with issue_valid_i and issue_ready_o both high, writing the entry at that edge with committed=killed=0.
REQ-015 SHALL drive issue_ready_o = (count_o < DEPTH), from registered count only; a pop in the same cycle does not raise it.
REQ-016 SHALL, on commit_valid_i, set committed (and killed if commit_kill_i) on the oldest valid, not-yet-committed entry with matching id, including an entry written at the same edge.
REQ-017 SHALL ignore commits matching no uncommitted entry, and kills arriving after commit.
REQ-018 SHALL run a head FSM with states IDLE, MEM_REQ, MEM_RESP, RETIRE, deciding from registered entry flags only.
REQ-019 SHALL transition IDLE -> RETIRE when head is valid and killed, or committed with is_mem=0.
REQ-020 SHALL transition IDLE -> MEM_REQ when head is committed, not killed, is_mem=1; otherwise stay in IDLE.
REQ-021 SHALL, in MEM_REQ, drive mem_valid_o=1 with mem_id_o/mem_we_o from head, stable until mem_ready_i; -> MEM_RESP on the handshake.
REQ-022 SHALL, in MEM_RESP, transition to RETIRE on mem_result_valid_i with mem_result_id_i equal to head id.
REQ-023 SHALL, in RETIRE, pulse retire_valid_o for exactly one cycle with head id and killed flag, pop the head, and return to IDLE.
REQ-024 SHALL keep count_o unchanged on simultaneous issue and pop; +1 on issue only; -1 on pop only.
REQ-025 SHALL set protocol_err_o on mem_result_valid_i outside MEM_RESP or with mismatched id; the result is otherwise ignored.
REQ-026 SHALL drive mem_id_o, mem_we_o, retire_id_o, retire_killed_o to 0 when their valid is low.
REQ-027 SHALL wrap read/write pointers modulo DEPTH without bubbles.

Reset
REQ-028 SHALL, on rst_i high at a clock edge, empty the queue, enter IDLE, clear protocol_err_o, and drive all outputs 0 except issue_ready_o=1, taking effect the next cycle.
REQ-029 SHALL discard in-flight mem handshakes and pending retires on reset mid-operation; no retire pulse follows for flushed entries.

Verification
REQ-030 Non-mem: issue id=3 with commit id=3 kill=0 in cycle 0 -> retire_valid_o=1, retire_id_o=3, retire_killed_o=0 in cycle 2 only.
REQ-031 Mem load: issue id=5 is_mem=1 we=0, commit cycle 0, mem_ready_i high in cycle 2, result id=5 in cycle 3 -> mem_valid_o high in cycle 2 only; retire id=5 in cycle 4.
REQ-032 Backpressure: mem_ready_i low 3 cycles -> mem_valid_o, mem_id_o, mem_we_o held constant until handshake.
REQ-033 Full: 4 issues without commit -> issue_ready_o=0, count_o=4; kill id of head -> head retires killed=1 two cycles later; issue_ready_o=1 the cycle after pop.
REQ-034 Out-of-order commit: issue ids 1,2; commit 2 then 1 -> retire order 1 then 2; stray result id=7 -> protocol_err_o=1.
REQ-035 Reset in MEM_REQ: rst_i high one cycle -> next cycle mem_valid_o=0, count_o=0, busy_o=0, no retire.
